nibble_scatter_stream: RTL and testbench

- Streaming inverse of the nibble compactor: consumes packed nibble words and expands them into 32-bit words.
- Each output nibble lane whose select bit is set receives the next buffered nibble, lowest lane first. Every other lane is zero.
- Sits between a packed-data source, such as a decompressor or bus de-serialiser, and consumers that need nibbles restored to sparse lane positions.
- Internal 16-nibble buffer decouples the input rate from the per-request consumption rate.

---
 rtl/nibble_scatter_stream.sv | 113 +++++++++++
 tb/tb_nibble_scatter_stream.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/nibble_scatter_stream.sv
// rtl/nibble_scatter_stream.sv - expands packed nibble words into sparse lane positions selected by a mask
module nibble_scatter_stream #(
   parameter int NIB_W   = 4,
   parameter int LANES   = 8,
   parameter int BUF_NIB = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NIB_W*LANES-1:0] in_data,
   input  logic [3:0]             in_cnt,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [LANES-1:0]       req_sel,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NIB_W*LANES-1:0] out_data,
   output logic [LANES-1:0]       out_sel,
   output logic [4:0]             level
);

   localparam int AW = $clog2(BUF_NIB);
   localparam int LW = $clog2(LANES);

   logic [NIB_W-1:0]       nib_q    [BUF_NIB];
   logic [NIB_W-1:0]       nib_d    [BUF_NIB];
   logic [NIB_W-1:0]       in_nib   [LANES];
   logic [NIB_W-1:0]       scat_nib [LANES];
   logic [NIB_W*LANES-1:0] scat_data;
   logic [4:0]             level_d;
   logic                   push_fire;
   logic                   req_fire;
   int                     pop_n;
   int                     push_n;
   int                     pop_eff;
   int                     push_eff;
   int                     base_i;
   int                     lvl_next;
   int                     k;

   // Unpack the incoming word and repack the scattered lanes with constant slices.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign in_nib[g]                      = in_data[g*NIB_W +: NIB_W];
      assign scat_data[g*NIB_W +: NIB_W]    = scat_nib[g];
   end

   // Handshake terms: popcount of the request mask and clamped push count.
   always_comb begin
      pop_n = 0;
      for (int l = 0; l < LANES; l++) begin
         if (req_sel[LW'(l)]) pop_n = pop_n + 1;
      end
      push_n = int'(in_cnt);
      if (push_n > LANES) push_n = LANES;
      in_ready  = (int'(level) <= BUF_NIB - LANES);
      req_ready = (pop_n <= int'(level)) && (!out_valid || out_ready);
      push_fire = in_valid && in_ready;
      req_fire  = req_valid && req_ready;
   end

   // Route the oldest buffered nibbles to the selected lanes, lowest lane first.
   always_comb begin
      k = 0;
      for (int l = 0; l < LANES; l++) begin
         scat_nib[l] = '0;
         if (req_sel[LW'(l)]) begin
            scat_nib[l] = nib_q[AW'(k)];
            k = k + 1;
         end
      end
   end

   // Next buffer image: shift down by the popped count, then append the push behind the survivors.
   always_comb begin
      pop_eff  = req_fire  ? pop_n  : 0;
      push_eff = push_fire ? push_n : 0;
      base_i   = int'(level) - pop_eff;
      lvl_next = base_i + push_eff;
      level_d  = 5'(lvl_next);
      for (int i = 0; i < BUF_NIB; i++) begin
         if (i >= lvl_next) begin
            nib_d[i] = '0;
         end else if (i >= base_i) begin
            nib_d[i] = in_nib[LW'(i - base_i)];
         end else begin
            nib_d[i] = nib_q[AW'(i + pop_eff)];
         end
      end
   end

   // Buffer, level and output register; reset discards everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         for (int i = 0; i < BUF_NIB; i++) nib_q[i] <= '0;
      end else begin
         level <= level_d;
         for (int i = 0; i < BUF_NIB; i++) nib_q[i] <= nib_d[i];
         if (req_fire) begin
            out_valid <= 1'b1;
            out_data  <= scat_data;
            out_sel   <= req_sel;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nibble_scatter_stream.sv
// tb/tb_nibble_scatter_stream.sv - directed table-driven bench for nibble_scatter_stream
module tb_nibble_scatter_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [3:0]  in_cnt;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_sel;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [7:0]  out_sel;
   logic [4:0]  level;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        iv;
      logic [31:0] idata;
      logic [3:0]  icnt;
      logic        rv;
      logic [7:0]  rsel;
      logic        ordy;
      logic        e_inr;
      logic        e_rqr;
      logic        e_ov;
      logic [31:0] e_od;
      logic [7:0]  e_os;
      logic [4:0]  e_lvl;
   } vec_t;

   vec_t tv [20];
   vec_t hv;

   nibble_scatter_stream dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_cnt    (in_cnt),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_sel   (req_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .level     (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      in_valid  = v.iv;
      in_data   = v.idata;
      in_cnt    = v.icnt;
      req_valid = v.rv;
      req_sel   = v.rsel;
      out_ready = v.ordy;
      #1;
      chk("in_ready", idx, in_ready, v.e_inr);
      chk("req_ready", idx, req_ready, v.e_rqr);
      @(posedge clk);
      #1;
      chk("out_valid", idx, out_valid, v.e_ov);
      chk("out_data", idx, out_data, v.e_od);
      chk("out_sel", idx, out_sel, v.e_os);
      chk("level", idx, level, v.e_lvl);
   endtask

   initial begin
      //          iv  idata         icnt  rv  rsel   ordy inr rqr ov  od            os     lvl
      tv[0]  = '{1, 32'h87654321, 4'd8, 0, 8'h00, 1,   1,  1,  0, 32'h00000000, 8'h00, 5'd8};
      tv[1]  = '{0, 32'h00000000, 4'd0, 1, 8'hA5, 1,   1,  1,  1, 32'h40300201, 8'hA5, 5'd4};
      tv[2]  = '{0, 32'h00000000, 4'd0, 1, 8'hFF, 1,   1,  0,  0, 32'h40300201, 8'hA5, 5'd4};
      tv[3]  = '{1, 32'h000000BA, 4'd2, 1, 8'hFF, 1,   1,  0,  0, 32'h40300201, 8'hA5, 5'd6};
      tv[4]  = '{1, 32'h000000BA, 4'd2, 1, 8'hFF, 1,   1,  0,  0, 32'h40300201, 8'hA5, 5'd8};
      tv[5]  = '{0, 32'h00000000, 4'd0, 1, 8'hFF, 1,   1,  1,  1, 32'hBABA8765, 8'hFF, 5'd0};
      tv[6]  = '{1, 32'h87654321, 4'd8, 0, 8'h00, 1,   1,  1,  0, 32'hBABA8765, 8'hFF, 5'd8};
      tv[7]  = '{1, 32'hFEDCBA98, 4'd8, 1, 8'h0F, 1,   1,  1,  1, 32'h00004321, 8'h0F, 5'd12};
      tv[8]  = '{0, 32'h00000000, 4'd0, 1, 8'h0F, 0,   0,  0,  1, 32'h00004321, 8'h0F, 5'd12};
      tv[9]  = '{0, 32'h00000000, 4'd0, 1, 8'h0F, 0,   0,  0,  1, 32'h00004321, 8'h0F, 5'd12};
      tv[10] = '{0, 32'h00000000, 4'd0, 1, 8'h0F, 0,   0,  0,  1, 32'h00004321, 8'h0F, 5'd12};
      tv[11] = '{0, 32'h00000000, 4'd0, 1, 8'h0F, 1,   0,  1,  1, 32'h00008765, 8'h0F, 5'd8};
      tv[12] = '{0, 32'h00000000, 4'd0, 1, 8'hFF, 1,   1,  1,  1, 32'hFEDCBA98, 8'hFF, 5'd0};
      tv[13] = '{0, 32'h00000000, 4'd0, 1, 8'h01, 1,   1,  0,  0, 32'hFEDCBA98, 8'hFF, 5'd0};
      tv[14] = '{0, 32'h00000000, 4'd0, 1, 8'h00, 1,   1,  1,  1, 32'h00000000, 8'h00, 5'd0};
      tv[15] = '{1, 32'hDEADBEEF, 4'd0, 0, 8'h00, 1,   1,  1,  0, 32'h00000000, 8'h00, 5'd0};
      tv[16] = '{1, 32'h12345678, 4'hF, 0, 8'h00, 1,   1,  1,  0, 32'h00000000, 8'h00, 5'd8};
      tv[17] = '{0, 32'h00000000, 4'd0, 1, 8'hFF, 1,   1,  1,  1, 32'h12345678, 8'hFF, 5'd0};
      tv[18] = '{1, 32'h87654321, 4'd8, 0, 8'h00, 1,   1,  1,  0, 32'h12345678, 8'hFF, 5'd8};
      tv[19] = '{1, 32'h87654321, 4'd8, 1, 8'h0F, 1,   1,  1,  1, 32'h00004321, 8'h0F, 5'd12};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_cnt    = '0;
      req_valid = 1'b0;
      req_sel   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 0, out_valid, 1'b0);
      chk("rst_out_data", 0, out_data, 32'h0);
      chk("rst_out_sel", 0, out_sel, 8'h0);
      chk("rst_level", 0, level, 5'd0);
      chk("rst_in_ready", 0, in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) apply(tv[i], i);

      // Asynchronous reset in the middle of a low clock phase with level=12 and a held output.
      @(negedge clk);
      in_valid  = 1'b0;
      req_valid = 1'b0;
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", 1, out_valid, 1'b0);
      chk("async_out_data", 1, out_data, 32'h0);
      chk("async_out_sel", 1, out_sel, 8'h0);
      chk("async_level", 1, level, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 1, in_ready, 1'b1);

      hv = '{1, 32'h87654321, 4'd1, 0, 8'h00, 1, 1, 1, 0, 32'h00000000, 8'h00, 5'd1};
      apply(hv, 100);
      hv = '{0, 32'h00000000, 4'd0, 1, 8'h80, 1, 1, 1, 1, 32'h10000000, 8'h80, 5'd0};
      apply(hv, 101);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
